// File: rtl/hamming_deint_rx.sv
// hamming_deint_rx
//   Serial receive back end for the Hamming/interleave link. Collects a
//   28-bit frame one bit per strobe, undoes the 4x7 block interleave, then
//   decodes four Hamming(7,4) codewords (one per cycle) and presents the
//   recovered 16-bit word with one error flag per codeword.
//
//   Build option: define HAMMING_RX_CORRECT_EN to apply single-bit
//   correction. Without it the block is detect-only: the data nibbles are
//   taken uncorrected, and err_mask is reported the same way.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   ser_in     in   received line bit, sampled when ser_valid=1
//   ser_valid  in   bit strobe
//   ser_sof    in   start of frame (bit t=0), qualified by ser_valid
//   data_out   out  [15:0] decoded word, held until the next frame completes
//   data_valid out  one-cycle pulse when data_out/err_mask update
//   err_mask   out  [3:0] bit r set when codeword r had a nonzero syndrome
//   overrun    out  one-cycle pulse the cycle after a strobe is dropped
//   state_dbg  out  [1:0] current FSM state (0 IDLE, 1 RECV, 2 DECODE, 3 OUT)
//
// Handshake: ser_valid is a plain strobe with no back-pressure. A strobe is
// consumed in IDLE (only with ser_sof) and in RECV; in DECODE/OUT it is
// dropped and flagged through overrun.

module hamming_deint_rx (
   input  logic        clk,
   input  logic        rst,
   input  logic        ser_in,
   input  logic        ser_valid,
   input  logic        ser_sof,
   output logic [15:0] data_out,
   output logic        data_valid,
   output logic [3:0]  err_mask,
   output logic        overrun,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RECV   = 2'd1,
      DECODE = 2'd2,
      OUT    = 2'd3
   } state_t;

   state_t      state;
   logic [4:0]  bit_cnt;
   // cw_buf[r][c]: bit c holds Hamming position c+1 of codeword r
   logic [6:0]  cw_buf [4];
   logic [1:0]  dec_idx;
   logic [15:0] data_shadow;
   logic [3:0]  err_shadow;

   // Decode datapath for the codeword selected by dec_idx
   logic [6:0]  cur_w;
   logic [6:0]  dat_w;
   logic [2:0]  syn;
   logic        syn_nz;
   logic [3:0]  nib;

   always_comb begin
      cur_w  = cw_buf[dec_idx];
      syn[0] = cur_w[0] ^ cur_w[2] ^ cur_w[4] ^ cur_w[6];
      syn[1] = cur_w[1] ^ cur_w[2] ^ cur_w[5] ^ cur_w[6];
      syn[2] = cur_w[3] ^ cur_w[4] ^ cur_w[5] ^ cur_w[6];
      syn_nz = |syn;
      dat_w  = cur_w;
`ifdef HAMMING_RX_CORRECT_EN
      // Syndrome value is the 1-based position of the bad bit
      if (syn_nz) begin
         dat_w[syn - 3'd1] = ~cur_w[syn - 3'd1];
      end
`endif
      // Data bits d1..d4 live at positions 3,5,6,7; d1 is the nibble MSB
      nib = {dat_w[2], dat_w[4], dat_w[5], dat_w[6]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         bit_cnt     <= 5'd0;
         dec_idx     <= 2'd0;
         data_shadow <= 16'h0000;
         err_shadow  <= 4'b0000;
         data_out    <= 16'h0000;
         err_mask    <= 4'b0000;
         data_valid  <= 1'b0;
         overrun     <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            cw_buf[i] <= 7'd0;
         end
      end else begin
         data_valid <= 1'b0;
         overrun    <= ser_valid && (state == DECODE || state == OUT);

         case (state)
            IDLE: begin
               if (ser_valid && ser_sof) begin
                  cw_buf[0][0] <= ser_in;
                  bit_cnt      <= 5'd1;
                  state        <= RECV;
               end
            end

            RECV: begin
               if (ser_valid) begin
                  if (ser_sof) begin
                     // Restart wins over completing the current frame
                     cw_buf[0][0] <= ser_in;
                     bit_cnt      <= 5'd1;
                  end else begin
                     // t%4 selects the codeword, t/4 the bit within it
                     cw_buf[bit_cnt[1:0]][bit_cnt[4:2]] <= ser_in;
                     if (bit_cnt == 5'd27) begin
                        bit_cnt <= 5'd0;
                        dec_idx <= 2'd0;
                        state   <= DECODE;
                     end else begin
                        bit_cnt <= bit_cnt + 5'd1;
                     end
                  end
               end
            end

            DECODE: begin
               // Codeword r fills data[15-4r -: 4]; 4*(3-r) == {~r,2'b00}
               data_shadow[{~dec_idx, 2'b00} +: 4] <= nib;
               err_shadow[dec_idx]                 <= syn_nz;
               dec_idx                             <= dec_idx + 2'd1;
               if (dec_idx == 2'd3) begin
                  // Load the outputs straight away so data_valid is high
                  // during the OUT cycle together with the new word.
                  data_out   <= {data_shadow[15:4], nib};
                  err_mask   <= {syn_nz, err_shadow[2:0]};
                  data_valid <= 1'b1;
                  state      <= OUT;
               end
            end

            OUT: begin
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign state_dbg = state;

endmodule

// File: doc/hamming_deint_rx.md
# hamming_deint_rx

Serial receive back end for the Hamming/interleave link. It accepts the 28-bit transmit stream one bit per strobe and undoes the 4×7 block interleave. It then decodes four Hamming(7,4) codewords with single-error correction and presents the recovered 16-bit word with per-codeword error flags. It sits downstream of the encoder/interleaver/waveform path in `top` and closes the loop back to a 16-bit `hamming_dec`-style result.

## Interface
Parameters: none; the frame geometry (4 codewords × 7 bits = 28 bits) is fixed.

Ports:
- `clk` input 1: system clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `ser_in` input 1: received line bit; sampled only when `ser_valid`=1.
- `ser_valid` input 1: bit strobe; one bit is accepted per cycle in which it is high.
- `ser_sof` input 1: start of frame; qualified by `ser_valid`; marks bit t=0.
- `data_out` output 16: decoded word; holds its value until the next frame completes.
- `data_valid` output 1: one-cycle pulse when `data_out`/`err_mask` update.
- `err_mask` output 4: bit r=1 means codeword r had a nonzero syndrome.
- `overrun` output 1: one-cycle pulse when a strobed bit is dropped.

## Operation
- **Bit mapping (transmit convention):**
  - Transmitted bit t (0..27) is bit c=t/4 of codeword r=t%4.
  - Codeword bit c is Hamming position c+1, in the order p1 p2 d1 p3 d2 d3 d4.
  - Codeword r carries nibble `data[15-4r : 12-4r]`, with d1 as the nibble MSB.
- **Syndrome:** {s3,s2,s1}.
  - s1 = XOR of positions 1,3,5,7.
  - s2 = XOR of positions 2,3,6,7.
  - s3 = XOR of positions 4,5,6,7.
  - A nonzero syndrome value is the position of the erroneous bit.
- **FSM, four states:** IDLE, RECV, DECODE, OUT.
  - IDLE: `ser_valid`&`ser_sof` stores bit 0, sets bit counter to 1, goes to RECV. `ser_valid` without `ser_sof` is ignored silently.
  - RECV: each `ser_valid` stores bit t at `buf[r][c]` and increments the counter. On the bit with counter=27, go to DECODE.
  - RECV restart: `ser_valid`&`ser_sof` while in RECV abandons the partial frame, stores the new bit 0 and sets the counter to 1. No `data_valid` and no `overrun` are raised.
  - DECODE: 4 cycles, one codeword per cycle in order r=0..3. Each cycle computes the syndrome, sets `err_mask[r]`, and writes the (corrected) nibble into the output shadow register.
  - OUT: asserts `data_valid` for one cycle, loads `data_out`/`err_mask` from the shadows, then returns to IDLE.
- **Correction:** a syndrome in 1..7 flips that one position before data extraction. A syndrome that points at a parity position leaves the data unchanged. A double error miscorrects silently; this is inherent to Hamming(7,4).
- **Overrun:** any `ser_valid` during DECODE or OUT is dropped and pulses `overrun` the following cycle. This includes a strobe carrying `ser_sof`.

## Timing
- **Reset (synchronous):**
  - state=IDLE, counter=0, buffer=0.
  - `data_out`=16'h0000, `err_mask`=4'b0000, `data_valid`=0, `overrun`=0.
  - Reset overrides any in-flight frame; nothing is emitted afterwards for the partial frame.
- **Latency:** if the final bit (t=27) is accepted in cycle N:
  - DECODE occupies cycles N+1..N+4.
  - `data_valid`=1 in cycle N+5, with `data_out`/`err_mask` valid from that cycle on.
  - The IDLE state is reached in N+6. The earliest next `ser_sof` accepted is in cycle N+6; a `ser_sof` at N+1..N+5 is an overrun.
- **Gaps:** `ser_valid` may have arbitrary gaps; only strobed cycles advance the counter. There is no timeout.
- **Simultaneous events:**
  - `ser_valid`&`ser_sof` on the cycle that would be bit 27: treated as a restart, so the frame is not completed.
  - `rst` with any input: reset wins.

## Configuration
Macro: `HAMMING_RX_CORRECT_EN`.
- **Defined:** single-bit correction is applied as described above.
- **Undefined:**
  - Detect-only mode; the data nibble is taken from the received bits uncorrected.
  - `err_mask` is still computed and reported identically.
  - The FSM, latency and all other behaviour are unchanged.

## Test plan
1. **Clean frame:** reset, then send the clean frame for 16'h147C (codewords 1101001, 1001100, 0001111, 0111100, written as positions 1..7) as 28 back-to-back strobes. Required: `data_valid` 5 cycles after the last bit, `data_out`=16'h147C, `err_mask`=4'b0000.
2. **Data-bit error:** same frame with t=8 inverted (codeword 0, d1). With the macro: `data_out`=16'h147C, `err_mask`=4'b0001. Without the macro: `data_out`=16'h947C, `err_mask`=4'b0001.
3. **Parity-bit error:** same frame with t=5 inverted (codeword 1, p2). Required in both builds: `data_out`=16'h147C, `err_mask`=4'b0010.
4. **Gaps and restart:** send the clean frame with random 0–3 cycle gaps between strobes. Interrupt it once with a new `ser_sof` at t=13, then send a full 16'hA5F0 frame. Required: a single `data_valid` with `data_out`=16'hA5F0 and no `overrun`.
5. **Overrun:** strobe `ser_valid`&`ser_sof` 2 cycles after bit 27. Required: one `overrun` pulse, then 16'h147C delivered normally. The dropped bit must not start a frame.
6. **Reset mid-frame:** assert `rst` after bit 20, then send a clean 16'h147C frame. Required: outputs read 0 after reset, and exactly one `data_valid` with 16'h147C.
